// File: rtl/baud_tick_generator.sv
// Baud tick generator: programmable divisor producing an oversampled
// receive-sample tick (rxenable) and a transmit-bit tick (txenable) that
// fires on every OVERSAMPLE-th receive tick.
//
// Divisor programming is a two-step bus sequence: the low byte is parked
// in a staging register, and the high-byte write commits both halves to
// the active divisor in one edge, so software never runs the counter on
// a half-updated divisor.
//
// Parameter legality: DIV_WIDTH 9..16, OVERSAMPLE a power of two 2..64.
module baud_tick_generator #(
   parameter int          DIV_WIDTH   = 16,
   parameter int          OVERSAMPLE  = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr,
   input  logic [1:0] ioaddr,
   input  logic [7:0] data,
   output logic       rxenable,
   output logic       txenable
);

   // Width of the high-byte slice that survives into the active divisor.
   localparam int HI_W  = DIV_WIDTH - 8;
   localparam int SUB_W = $clog2(OVERSAMPLE);

   localparam logic [DIV_WIDTH-1:0] RST_DIV  = DEFAULT_DIV[DIV_WIDTH-1:0];
   localparam logic [7:0]           RST_LOW  = DEFAULT_DIV[7:0];
   localparam logic [DIV_WIDTH-1:0] DIV_ZERO = '0;
   localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
   localparam logic [SUB_W-1:0]     SUB_ONE  = SUB_W'(1);
   localparam logic [SUB_W-1:0]     SUB_LAST = SUB_W'(OVERSAMPLE - 1);

   localparam logic [1:0] ADDR_DIV_LO = 2'b10;
   localparam logic [1:0] ADDR_DIV_HI = 2'b11;

   logic [7:0]           stage_q;   // low-byte staging register
   logic [DIV_WIDTH-1:0] div_q;     // active divisor
   logic [DIV_WIDTH-1:0] cnt_q;     // period down counter
   logic [SUB_W-1:0]     sub_q;     // rx ticks seen within the current tx bit

   logic                 wr_low;
   logic                 commit;
   logic [DIV_WIDTH-1:0] new_div;
   logic                 tick;
   logic                 sub_wrap;

   // Decode the bus strobe; addresses 2'b00/2'b01 fall through untouched.
   always_comb begin
      wr_low  = wr && (ioaddr == ADDR_DIV_LO);
      commit  = wr && (ioaddr == ADDR_DIV_HI);
      // High-byte bits above the divisor width are simply dropped.
      new_div = {data[HI_W-1:0], stage_q};
   end

   // Period expiry. A commit on the same edge wins, so the old period's
   // final tick is suppressed and the new divisor starts cleanly. A zero
   // divisor leaves the counter parked at 0 with no tick.
   always_comb begin
      tick     = !commit && (cnt_q == DIV_ZERO) && (div_q != DIV_ZERO);
      sub_wrap = (sub_q == SUB_LAST);
   end

   // Any unused upper data bits (narrow divisor builds) are tied off here.
   generate
      if (HI_W < 8) begin : g_unused_hi
         logic unused_hi;
         assign unused_hi = ^data[7:HI_W];
      end
   endgenerate

   // Low-byte staging: only a low-byte write touches it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stage_q <= RST_LOW;
      else if (wr_low)
         stage_q <= data;
   end

   // Active divisor: replaced atomically by the high-byte commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         div_q <= RST_DIV;
      else if (commit)
         div_q <= new_div;
   end

   // Down counter: load on commit, count to zero, reload on expiry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= RST_DIV;
      else if (commit)
         cnt_q <= new_div;
      else if (cnt_q != DIV_ZERO)
         cnt_q <= cnt_q - DIV_ONE;
      else if (div_q != DIV_ZERO)
         cnt_q <= div_q;
   end

   // Oversample sub-counter: advances per rx tick; the power-of-two width
   // makes the wrap from OVERSAMPLE-1 to 0 a natural rollover.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sub_q <= '0;
      else if (commit)
         sub_q <= '0;
      else if (tick)
         sub_q <= sub_q + SUB_ONE;
   end

   // Registered single-cycle ticks; tx rides on the rx tick that wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxenable <= 1'b0;
         txenable <= 1'b0;
      end else begin
         rxenable <= tick;
         txenable <= tick && sub_wrap;
      end
   end

endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed bench for baud_tick_generator: DIV_WIDTH=12, OVERSAMPLE=4,
// DEFAULT_DIV=3. Each task drives one scenario and checks inline.
module tb_baud_tick_generator;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr = 1'b0;
   logic [1:0] ioaddr = 2'b00;
   logic [7:0] data = 8'h00;
   logic       rxenable;
   logic       txenable;

   int n_cmp = 0;
   int n_bad = 0;

   baud_tick_generator #(
      .DIV_WIDTH  (12),
      .OVERSAMPLE (4),
      .DEFAULT_DIV(16'd3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr),
      .ioaddr  (ioaddr),
      .data    (data),
      .rxenable(rxenable),
      .txenable(txenable)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; outputs are sampled 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle bus write; returns just after the edge that took it.
   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      wr = 1'b1;
      ioaddr = a;
      data = d;
      step();
      wr = 1'b0;
      ioaddr = 2'b00;
      data = 8'h00;
   endtask

   // Edges until rx (or tx) is seen high; -1 if the limit expires.
   task automatic wait_ev(input bit use_tx, input int limit, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (((use_tx ? txenable : rxenable) !== 1'b1) && (n < limit));
      if ((use_tx ? txenable : rxenable) !== 1'b1) n = -1;
   endtask

   task automatic test_reset();
      int n;
      bit exp_rx, exp_tx;
      rst = 1'b0;
      repeat (3) step();
      n_cmp++; if (rxenable !== 1'b0) begin n_bad++; $display("FAIL reset_rx: got %b want 0", rxenable); end
      n_cmp++; if (txenable !== 1'b0) begin n_bad++; $display("FAIL reset_tx: got %b want 0", txenable); end
      n_cmp++; if (dut.cnt_q !== 12'd3) begin n_bad++; $display("FAIL reset_cnt: got %0h want 3", dut.cnt_q); end
      n_cmp++; if (dut.sub_q !== 2'd0) begin n_bad++; $display("FAIL reset_sub: got %0h want 0", dut.sub_q); end
      n_cmp++; if (dut.stage_q !== 8'h03) begin n_bad++; $display("FAIL reset_stage: got %0h want 03", dut.stage_q); end
      n_cmp++; if (dut.div_q !== 12'h003) begin n_bad++; $display("FAIL reset_div: got %0h want 003", dut.div_q); end
      rst = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         step();
         exp_rx = (e % 4 == 0);
         exp_tx = (e == 16);
         n_cmp++; if (rxenable !== exp_rx) begin n_bad++; $display("FAIL boot_rx edge %0d: got %b want %b", e, rxenable, exp_rx); end
         n_cmp++; if (txenable !== exp_tx) begin n_bad++; $display("FAIL boot_tx edge %0d: got %b want %b", e, txenable, exp_tx); end
      end
      wait_ev(1'b1, 100, n);
      n_cmp++; if (n !== 12) begin n_bad++; $display("FAIL boot_tx_next: got %0d want 12", n); end
      wait_ev(1'b1, 100, n);
      n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL boot_tx_period: got %0d want 16", n); end
   endtask

   // Commit lands on the edge where the old period would expire.
   task automatic test_commit_period();
      bit exp_rx, exp_tx;
      step();
      step();
      bus_write(2'b10, 8'h05);
      bus_write(2'b11, 8'h00);
      n_cmp++; if (rxenable !== 1'b0) begin n_bad++; $display("FAIL commit_rx: got %b want 0", rxenable); end
      n_cmp++; if (txenable !== 1'b0) begin n_bad++; $display("FAIL commit_tx: got %b want 0", txenable); end
      for (int e = 1; e <= 24; e++) begin
         step();
         exp_rx = (e % 6 == 0);
         exp_tx = (e == 24);
         n_cmp++; if (rxenable !== exp_rx) begin n_bad++; $display("FAIL div5_rx edge %0d: got %b want %b", e, rxenable, exp_rx); end
         n_cmp++; if (txenable !== exp_tx) begin n_bad++; $display("FAIL div5_tx edge %0d: got %b want %b", e, txenable, exp_tx); end
      end
   endtask

   task automatic test_staging();
      int n;
      bus_write(2'b10, 8'h09);
      wait_ev(1'b0, 50, n);
      wait_ev(1'b0, 50, n);
      n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL staged_period: got %0d want 6", n); end
      n_cmp++; if (dut.div_q !== 12'h005) begin n_bad++; $display("FAIL staged_div: got %0h want 005", dut.div_q); end
      bus_write(2'b11, 8'h00);
      n_cmp++; if (rxenable !== 1'b0) begin n_bad++; $display("FAIL staged_commit_rx: got %b want 0", rxenable); end
      wait_ev(1'b0, 50, n);
      n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL div9_first: got %0d want 10", n); end
      wait_ev(1'b0, 50, n);
      n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL div9_period: got %0d want 10", n); end
   endtask

   task automatic test_overwrite_and_ignored();
      int n;
      bus_write(2'b10, 8'h20);
      bus_write(2'b10, 8'h02);
      bus_write(2'b11, 8'h00);
      n_cmp++; if (dut.div_q !== 12'h002) begin n_bad++; $display("FAIL overwrite_div: got %0h want 002", dut.div_q); end
      wait_ev(1'b0, 50, n);
      n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL div2_first: got %0d want 3", n); end
      bus_write(2'b00, 8'h55);
      bus_write(2'b01, 8'hAA);
      n_cmp++; if (dut.stage_q !== 8'h02) begin n_bad++; $display("FAIL ignored_stage: got %0h want 02", dut.stage_q); end
      n_cmp++; if (dut.div_q !== 12'h002) begin n_bad++; $display("FAIL ignored_div: got %0h want 002", dut.div_q); end
      wait_ev(1'b0, 50, n);
      wait_ev(1'b0, 50, n);
      n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL ignored_period: got %0d want 3", n); end
   endtask

   task automatic test_div1();
      int n;
      bus_write(2'b10, 8'h01);
      bus_write(2'b11, 8'h00);
      wait_ev(1'b0, 50, n);
      n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL div1_first: got %0d want 2", n); end
      wait_ev(1'b0, 50, n);
      n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL div1_period: got %0d want 2", n); end
      wait_ev(1'b1, 50, n);
      n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL div1_tx_first: got %0d want 4", n); end
      wait_ev(1'b1, 50, n);
      n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL div1_tx_period: got %0d want 8", n); end
   endtask

   task automatic test_stop();
      int n, hits;
      bus_write(2'b10, 8'h00);
      bus_write(2'b11, 8'h00);
      n_cmp++; if (dut.cnt_q !== 12'd0) begin n_bad++; $display("FAIL stop_cnt: got %0h want 0", dut.cnt_q); end
      hits = 0;
      for (int i = 0; i < 100; i++) begin
         if (rxenable !== 1'b0 || txenable !== 1'b0) hits++;
         step();
      end
      n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL stop_ticks: got %0d want 0", hits); end
      n_cmp++; if (dut.cnt_q !== 12'd0) begin n_bad++; $display("FAIL stop_cnt_hold: got %0h want 0", dut.cnt_q); end
      bus_write(2'b10, 8'h02);
      n_cmp++; if (rxenable !== 1'b0) begin n_bad++; $display("FAIL stop_lowwr_rx: got %b want 0", rxenable); end
      bus_write(2'b11, 8'h00);
      wait_ev(1'b0, 50, n);
      n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL restart_first: got %0d want 3", n); end
   endtask

   task automatic test_max();
      int n;
      bus_write(2'b10, 8'hFF);
      bus_write(2'b11, 8'hFF);
      n_cmp++; if (dut.div_q !== 12'hFFF) begin n_bad++; $display("FAIL max_div: got %0h want FFF", dut.div_q); end
      n_cmp++; if (rxenable !== 1'b0) begin n_bad++; $display("FAIL max_commit_rx: got %b want 0", rxenable); end
      wait_ev(1'b0, 5000, n);
      n_cmp++; if (n !== 4096) begin n_bad++; $display("FAIL max_first: got %0d want 4096", n); end
      wait_ev(1'b0, 5000, n);
      n_cmp++; if (n !== 4096) begin n_bad++; $display("FAIL max_period: got %0d want 4096", n); end
   endtask

   task automatic test_reset_mid();
      int n;
      bus_write(2'b10, 8'h05);
      bus_write(2'b11, 8'h00);
      wait_ev(1'b0, 50, n);
      // Reset while rx is high must clear it without waiting for a clock.
      rst = 1'b0;
      #1;
      n_cmp++; if (rxenable !== 1'b0) begin n_bad++; $display("FAIL async_rx: got %b want 0", rxenable); end
      rst = 1'b1;
      wait_ev(1'b0, 50, n);
      n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL post_reset_first: got %0d want 4", n); end
      step();
      step();
      // Two clocks before the next tick.
      rst = 1'b0;
      #1;
      n_cmp++; if (rxenable !== 1'b0) begin n_bad++; $display("FAIL mid_rx: got %b want 0", rxenable); end
      n_cmp++; if (txenable !== 1'b0) begin n_bad++; $display("FAIL mid_tx: got %b want 0", txenable); end
      n_cmp++; if (dut.cnt_q !== 12'd3) begin n_bad++; $display("FAIL mid_cnt: got %0h want 3", dut.cnt_q); end
      n_cmp++; if (dut.sub_q !== 2'd0) begin n_bad++; $display("FAIL mid_sub: got %0h want 0", dut.sub_q); end
      n_cmp++; if (dut.stage_q !== 8'h03) begin n_bad++; $display("FAIL mid_stage: got %0h want 03", dut.stage_q); end
      n_cmp++; if (dut.div_q !== 12'h003) begin n_bad++; $display("FAIL mid_div: got %0h want 003", dut.div_q); end
      step();
      n_cmp++; if (rxenable !== 1'b0) begin n_bad++; $display("FAIL mid_hold_rx: got %b want 0", rxenable); end
      rst = 1'b1;
      wait_ev(1'b0, 50, n);
      n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL mid_release_first: got %0d want 4", n); end
   endtask

   initial begin
      test_reset();
      test_commit_period();
      test_staging();
      test_overwrite_and_ignored();
      test_div1();
      test_stop();
      test_max();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
